// File: rtl/dcache_pkg.sv
// Shared FSM state type and address-geometry helpers for the set-associative data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_REFILL    = 2'd2
   } state_t;

   // Tree-PLRU bits needed for a 4-way set; 2-way uses a single LRU bit.
   localparam int PLRU4_W = 3;

   function automatic int off_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_w, input int sets);
      return addr_w - off_w(line_w) - idx_w(sets);
   endfunction

   function automatic int repl_w(input int ways);
      return (ways == 4) ? PLRU4_W : 1;
   endfunction

   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/dcache_plru.sv
// Victim selection and replacement-state update for one set; purely combinational,
// no backpressure. Replacement bits point toward the way to evict next.
module dcache_plru
   import dcache_pkg::*;
#(
   parameter int WAYS = 2
) (
   input  logic [repl_w(WAYS)-1:0] repl,
   input  logic [WAYS-1:0]         valid,
   input  logic [way_w(WAYS)-1:0]  acc_way,
   output logic [way_w(WAYS)-1:0]  victim,
   output logic [repl_w(WAYS)-1:0] repl_next
);

   localparam int WW = way_w(WAYS);

   logic [WW-1:0] lru_way;

   // Lowest-index invalid way wins over the recency choice.
   always_comb begin
      victim = lru_way;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) victim = WW'(w);
      end
   end

   generate
      if (WAYS == 4) begin : g_tree
         always_comb begin
            lru_way      = repl[0] ? {1'b1, repl[2]} : {1'b0, repl[1]};
            repl_next    = repl;
            repl_next[0] = ~acc_way[1];
            if (acc_way[1]) repl_next[2] = ~acc_way[0];
            else            repl_next[1] = ~acc_way[0];
         end
      end else if (WAYS == 2) begin : g_bit
         assign lru_way   = repl;
         assign repl_next = ~acc_way;
      end else begin : g_direct
         assign lru_way   = '0;
         assign repl_next = repl;
      end
   endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// Write-back set-associative data cache: load/store hits complete in the request cycle,
// misses stall the CPU through WRITEBACK/REFILL. Optional counters under DCACHE_STATS_EN.
module dcache_assoc
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_W = 256,
   parameter int SETS   = 16,
   parameter int WAYS   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [DATA_W-1:0] p1_data_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_stall_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int OFF_W  = off_w(LINE_W);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int SEL_W  = OFF_W - BYTE_W;
   localparam int RW     = repl_w(WAYS);
   localparam int WW     = way_w(WAYS);

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [SEL_W-1:0] sel;
   logic             unused_byte_bits;

   assign idx              = p1_addr_i[OFF_W +: IDX_W];
   assign tag              = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign sel              = p1_addr_i[BYTE_W +: SEL_W];
   assign unused_byte_bits = ^p1_addr_i[BYTE_W-1:0];

   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] line_q  [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [RW-1:0]     repl_q  [SETS];

   state_t            state;
   state_t            state_next;
   logic [WW-1:0]     vic_q;
   logic [WW-1:0]     victim;
   logic [WW-1:0]     hit_way;
   logic [WW-1:0]     acc_way;
   logic [RW-1:0]     repl_next;
   logic              hit;
   logic              req;
   logic              acc_hit;
   logic              miss_start;
   logic              refill_done;
   logic [DATA_W-1:0] hit_word;

   assign req         = p1_MemRead_i | p1_MemWrite_i;
   assign acc_hit     = (state == ST_IDLE) && req && hit;
   assign miss_start  = (state == ST_IDLE) && req && !hit;
   assign refill_done = (state == ST_REFILL) && mem_ack_i;
   assign hit_word    = line_q[idx][hit_way][sel*DATA_W +: DATA_W];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
      end
   end

   // During refill the way being filled becomes most-recent; otherwise the hit way does.
   assign acc_way = (state == ST_REFILL) ? vic_q : hit_way;

   dcache_plru #(
      .WAYS (WAYS)
   ) u_plru (
      .repl      (repl_q[idx]),
      .valid     (valid_q[idx]),
      .acc_way   (acc_way),
      .victim    (victim),
      .repl_next (repl_next)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (miss_start) begin
               state_next = (valid_q[idx][victim] && dirty_q[idx][victim]) ? ST_WRITEBACK
                                                                          : ST_REFILL;
            end
         end
         ST_WRITEBACK: if (mem_ack_i) state_next = ST_REFILL;
         ST_REFILL:    if (mem_ack_i) state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state)
         ST_WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_q[idx][vic_q], idx, {OFF_W{1'b0}}};
            mem_data_o   = line_q[idx][vic_q];
         end
         ST_REFILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
         end
         default: ;
      endcase
      p1_stall_o = (state != ST_IDLE) || (req && !hit);
      p1_data_o  = (acc_hit && !p1_MemWrite_i) ? hit_word : '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         vic_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            repl_q[s]  <= '0;
         end
      end else begin
         if (miss_start) vic_q <= victim;
         if (refill_done) begin
            valid_q[idx][vic_q] <= 1'b1;
            dirty_q[idx][vic_q] <= 1'b0;
            repl_q[idx]         <= repl_next;
         end else if (acc_hit) begin
            repl_q[idx] <= repl_next;
            if (p1_MemWrite_i) dirty_q[idx][hit_way] <= 1'b1;
         end
      end
   end

   // Tags and lines carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk_i) begin
      if (refill_done) begin
         line_q[idx][vic_q] <= mem_data_i;
         tag_q[idx][vic_q]  <= tag;
      end else if (acc_hit && p1_MemWrite_i) begin
         line_q[idx][hit_way][sel*DATA_W +: DATA_W] <= p1_data_i;
      end
   end

`ifdef DCACHE_STATS_EN
   // The replayed access right after a refill completes the same miss, so it is not a hit.
   logic replay_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         replay_q   <= 1'b0;
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (refill_done)            replay_q <= 1'b1;
         else if (state == ST_IDLE)  replay_q <= 1'b0;
         if (acc_hit && !replay_q && (hit_cnt_o != '1)) hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (miss_start && (miss_cnt_o != '1))          miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed corner cases, then random traffic checked against a
// recency-stamped cache model, a flat word shadow and a latency-programmable memory.
module tb_dcache_assoc;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LINE_W = 256;
   localparam int SETS   = 16;
   localparam int WAYS   = 2;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [DATA_W-1:0] p1_data_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic              p1_MemRead_i;
   logic              p1_MemWrite_i;
   logic [DATA_W-1:0] p1_data_o;
   logic              p1_stall_o;
`ifdef DCACHE_STATS_EN
   logic [31:0]       hit_cnt_o;
   logic [31:0]       miss_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   dcache_assoc #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LINE_W (LINE_W),
      .SETS   (SETS),
      .WAYS   (WAYS)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i),
      .mem_data_o    (mem_data_o),
      .mem_addr_o    (mem_addr_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .p1_data_i     (p1_data_i),
      .p1_addr_i     (p1_addr_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o     (hit_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [LINE_W-1:0] mem_q [logic [31:0]];
   int mem_lat = 3;
   int ack_cnt = 0;

   function automatic logic [LINE_W-1:0] line_init(input logic [31:0] la);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = {la[23:0], 8'(i)} ^ 32'h5A5A_0000;
      return l;
   endfunction

   initial begin
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_i || mem_ack_i) begin
            mem_ack_i = 1'b0;
            ack_cnt   = 0;
         end
         if (rst_i && mem_enable_o) begin
            ack_cnt++;
            if (ack_cnt >= mem_lat) begin
               if (mem_write_o) mem_q[mem_addr_o] = mem_data_o;
               else mem_data_i = mem_q.exists(mem_addr_o) ? mem_q[mem_addr_o] : line_init(mem_addr_o);
               mem_ack_i = 1'b1;
            end
         end
      end
   end

   // ---------------- cache reference model ----------------
   bit          m_val   [SETS][WAYS];
   bit          m_dirty [SETS][WAYS];
   logic [22:0] m_tag   [SETS][WAYS];
   int          m_stamp [SETS][WAYS];
   int          now = 0;
   logic [31:0] shadow  [logic [31:0]];

   task automatic wipe();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_val[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_stamp[s][w] = 0;
         end
      mem_q.delete();
      shadow.delete();
      now = 0;
   endtask

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      if (shadow.exists({2'b00, a[31:2]})) return shadow[{2'b00, a[31:2]}];
      l = line_init({a[31:5], 5'b0});
      return l[a[4:2]*32 +: 32];
   endfunction

   // op: 0 load, 1 store, 2 load+store (a store)
   task automatic access(input logic [31:0] a, input int op, input logic [31:0] wd,
                         output int cyc, output logic [31:0] wb_a, output logic [31:0] rf_a,
                         output logic [31:0] rd);
      int          s;
      logic [22:0] t;
      int          way;
      int          vic;
      bit          hit;
      bit          wb_seen;
      bit          exp_wb;
      logic [31:0] exp_wb_a;
      int          exp_cyc;
      logic [31:0] exp_rd;
      s = int'(a[8:5]);
      t = a[31:9];
      hit = 0; way = 0; vic = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_val[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
      if (!hit) begin
         vic = -1;
         for (int w = 0; w < WAYS; w++) if (!m_val[s][w] && vic < 0) vic = w;
         if (vic < 0) begin
            vic = 0;
            for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][vic]) vic = w;
         end
      end
      exp_wb   = !hit && m_val[s][vic] && m_dirty[s][vic];
      exp_wb_a = exp_wb ? {m_tag[s][vic], a[8:5], 5'b0} : 32'h0;
      exp_cyc  = hit ? 0 : (exp_wb ? 2 * mem_lat + 1 : mem_lat + 1);
      exp_rd   = exp_word(a);

      @(posedge clk_i); #1;
      p1_addr_i     = a;
      p1_data_i     = wd;
      p1_MemRead_i  = (op != 1);
      p1_MemWrite_i = (op != 0);
      cyc = 0; wb_seen = 0; wb_a = '0; rf_a = '0;
      @(negedge clk_i);
      while (p1_stall_o && cyc < 400) begin
         if (mem_enable_o && mem_write_o && !wb_seen) begin wb_seen = 1; wb_a = mem_addr_o; end
         if (mem_enable_o && !mem_write_o) rf_a = mem_addr_o;
         cyc++;
         @(negedge clk_i);
      end
      rd = p1_data_o;
      chk("stall_cycles", 64'(cyc), 64'(exp_cyc));
      chk("wb_seen", 64'(wb_seen), 64'(exp_wb));
      chk("wb_addr", 64'(wb_a), 64'(exp_wb_a));
      if (!hit) chk("refill_addr", 64'(rf_a), 64'({a[31:5], 5'b0}));
      if (op == 0) chk("load_data", 64'(rd), 64'(exp_rd));

      if (!hit) begin
         way = vic; m_val[s][way] = 1; m_tag[s][way] = t; m_dirty[s][way] = 0;
      end
      now++;
      m_stamp[s][way] = now;
      if (op != 0) begin
         m_dirty[s][way] = 1;
         shadow[{2'b00, a[31:2]}] = wd;
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk_i); #1;
      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
      repeat (n - 1) @(posedge clk_i);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      int          cyc;
      int          n;
      logic [31:0] wb_a;
      logic [31:0] rf_a;
      logic [31:0] rd;
      logic [31:0] a;
      int          op;

      rst_i = 1'b0; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
      wipe();
      #12;
      chk("rst_enable", 64'(mem_enable_o), 64'd0);
      chk("rst_write", 64'(mem_write_o), 64'd0);
      chk("rst_addr", 64'(mem_addr_o), 64'd0);
      chk("rst_mdata", 64'(|mem_data_o), 64'd0);
      chk("rst_pdata", 64'(p1_data_o), 64'd0);
      @(negedge clk_i); rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_stall", 64'(p1_stall_o), 64'd0);
`ifdef DCACHE_STATS_EN
      chk("rst_hits", 64'(hit_cnt_o), 64'd0);
      chk("rst_misses", 64'(miss_cnt_o), 64'd0);
`endif

      // cold load, 3-cycle memory
      mem_lat = 3;
      access(32'h40, 0, 32'h0, cyc, wb_a, rf_a, rd);
      chk("cold_stall", 64'(cyc), 64'd4);
      chk("cold_refill", 64'(rf_a), 64'h40);
      chk("cold_data", 64'(rd), 64'h5A5A_4000);

      // store hit then reload
      access(32'h44, 1, 32'hDEAD_BEEF, cyc, wb_a, rf_a, rd);
      chk("store_stall", 64'(cyc), 64'd0);
      access(32'h44, 0, 32'h0, cyc, wb_a, rf_a, rd);
      chk("reload_data", 64'(rd), 64'hDEAD_BEEF);

      // dirty eviction
      mem_lat = 2;
      access(32'h040, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h240, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h440, 0, 32'h0, cyc, wb_a, rf_a, rd);
      chk("evict_wb_addr", 64'(wb_a), 64'h40);
      chk("evict_refill", 64'(rf_a), 64'h440);
      chk("evict_stall", 64'(cyc), 64'd5);

      // LRU order: 0x040, 0x240, 0x040, 0x440 evicts 0x240
      access(32'h040, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h240, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h040, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h440, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h044, 0, 32'h0, cyc, wb_a, rf_a, rd);
      chk("lru_keep_hit", 64'(cyc), 64'd0);
      chk("lru_keep_data", 64'(rd), 64'hDEAD_BEEF);
      access(32'h240, 0, 32'h0, cyc, wb_a, rf_a, rd);
      chk("lru_victim_miss", 64'(cyc), 64'd3);

      // asynchronous reset during refill
      idle(2);
      mem_lat = 50;
      @(posedge clk_i); #1;
      p1_addr_i = 32'h1C0; p1_MemRead_i = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!mem_enable_o && n < 10) begin n++; @(negedge clk_i); end
      chk("midrst_enable_before", 64'(mem_enable_o), 64'd1);
      #2 rst_i = 1'b0;
      #1;
      chk("midrst_enable", 64'(mem_enable_o), 64'd0);
      chk("midrst_write", 64'(mem_write_o), 64'd0);
      chk("midrst_addr", 64'(mem_addr_o), 64'd0);
      chk("midrst_pdata", 64'(p1_data_o), 64'd0);
      p1_MemRead_i = 1'b0;
      @(negedge clk_i); rst_i = 1'b1;
      wipe();
      mem_lat = 2;
      access(32'h1C0, 0, 32'h0, cyc, wb_a, rf_a, rd);
      chk("midrst_remiss", 64'(cyc), 64'd3);

      // 2 misses, 3 hits since the reset
      access(32'h1C0, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h1C4, 1, 32'h1234_5678, cyc, wb_a, rf_a, rd);
      access(32'h080, 0, 32'h0, cyc, wb_a, rf_a, rd);
      access(32'h084, 0, 32'h0, cyc, wb_a, rf_a, rd);
      idle(2);
`ifdef DCACHE_STATS_EN
      chk("stats_hits", 64'(hit_cnt_o), 64'd3);
      chk("stats_misses", 64'(miss_cnt_o), 64'd2);
`endif

      // random traffic over 4 sets x 4 tags to force conflicts
      for (int i = 0; i < 300; i++) begin
         mem_lat = int'($urandom_range(1, 4));
         a  = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2));
         op = int'($urandom_range(0, 2));
         access(a, op, $urandom, cyc, wb_a, rf_a, rd);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, meaning CPU byte-address width.
REQ-002 SHALL provide parameter DATA_W, default 32, meaning CPU word width.
REQ-003 SHALL provide parameter LINE_W, default 256, meaning cache line and memory beat width in bits.
REQ-004 SHALL provide parameter SETS, default 16, meaning the number of sets; it is a power of 2, ≥2.
REQ-005 SHALL provide parameter WAYS, default 2, meaning associativity; legal values are 1, 2 or 4.
REQ-006 SHALL provide the ports, in this order:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_data_i  in  LINE_W  refill line from memory.
- mem_ack_i  in  1  one-cycle memory completion pulse.
- mem_data_o  out  LINE_W  write-back line.
- mem_addr_o  out  ADDR_W  line-aligned memory address.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- p1_data_i  in  DATA_W  store data.
- p1_addr_i  in  ADDR_W  CPU byte address.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  DATA_W  load data.
- p1_stall_o  out  1  pipeline stall.

Function
REQ-007 SHALL split the address into three fields:
- offset = log2(LINE_W/8) LSBs, with the word select taken from offset[MSB:log2(DATA_W/8)];
- index = the next log2(SETS) bits;
- tag = the remaining bits.
REQ-008 SHALL keep, per set and way: a valid bit, a dirty bit, a tag and a line; and per set: replacement state (WAYS=2 one LRU bit, WAYS=4 3-bit tree-PLRU, WAYS=1 none).
REQ-009 SHALL declare a hit when any way in the indexed set is valid with a matching tag; at most one way matches.
REQ-010 SHALL, on a load hit in IDLE, drive p1_data_o combinationally in the same cycle, with p1_stall_o=0.
REQ-011 SHALL, on a store hit in IDLE, write the word and set dirty at the next edge, with p1_stall_o=0.
REQ-012 SHALL update the replacement state on every hit and on every refill-completion, marking the accessed way most-recent.
REQ-013 SHALL drive p1_stall_o=1 combinationally whenever a request is present and no hit exists, or the FSM is not IDLE.
REQ-014 SHALL choose the victim as the lowest-index invalid way if any exists, otherwise the LRU/PLRU way.
REQ-015 SHALL implement the FSM states IDLE, WRITEBACK and REFILL:
- IDLE: on a miss, go to WRITEBACK if the victim is valid and dirty, else to REFILL.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,0}, mem_data_o=victim line; on mem_ack_i go to REFILL.
- REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,index,0}; on mem_ack_i capture mem_data_i into the victim (valid=1, dirty=0, tag updated) and go to IDLE.
REQ-016 SHALL hold mem_enable_o, mem_write_o and mem_addr_o stable from request entry until the cycle of mem_ack_i; mem_enable_o=0 in IDLE.
REQ-017 SHALL complete a miss in IDLE on the cycle after refill, via the normal hit path; clean-miss stall = refill latency + 1 cycle.
REQ-018 SHALL ignore mem_ack_i while in IDLE.
REQ-019 SHALL treat p1_MemRead_i and p1_MemWrite_i asserted together as a store.
REQ-020 SHALL require the CPU to hold its address and data stable while p1_stall_o=1.

Reset
REQ-021 SHALL, when rst_i=0 (asynchronous, including mid-miss):
- set the FSM to IDLE;
- clear all valid, dirty and replacement bits;
- drive mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0 and p1_data_o=0 immediately.
REQ-022 SHALL assert p1_stall_o after reset release only for a request that misses.

Configuration
REQ-023 SHALL, with DCACHE_STATS_EN defined, add the outputs hit_cnt_o (32-bit) and miss_cnt_o (32-bit):
- each counts accepted IDLE requests, hit or miss respectively;
- a miss counts once per miss;
- both saturate at all-ones and reset to 0.
REQ-024 SHALL, without DCACHE_STATS_EN defined, have neither port nor counter logic.

Structure
REQ-025 SHALL place in a shared package dcache_pkg:
- the FSM state enum;
- the offset, index and tag width derivation functions;
- the replacement-state width constant.
REQ-026 SHALL instantiate one sub-module, dcache_plru (victim select and update, parametrised by WAYS).

Verification
REQ-027 SHALL cover cold load 0x0000_0040 with a 3-cycle ack: one refill at mem_addr_o=0x40, mem_write_o=0; stall for 4 cycles; then data = word 0 of the line.
REQ-028 SHALL cover store 0xDEADBEEF to 0x44 after REQ-027: zero stall; a reload of 0x44 returns 0xDEADBEEF.
REQ-029 SHALL cover (WAYS=2, SETS=16) loads to 0x040, 0x240, 0x440 with 0x040 dirty: the third load writes back 0x040 first (mem_write_o=1), then refills 0x440.
REQ-030 SHALL cover (WAYS=2) access to 0x040, 0x240, 0x040, 0x440: the victim is 0x240, and 0x040 then hits.
REQ-031 SHALL cover rst_i=0 during REFILL: mem_enable_o falls asynchronously; a following load of the same address misses again.
REQ-032 SHALL cover, with DCACHE_STATS_EN, 3 hits and 2 misses: hit_cnt_o=3, miss_cnt_o=2.
